cmos_pixel_pack: RTL



---
 rtl/cmos_pixel_pack_if.sv | 27 ++
 rtl/cmos_pixel_pack.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_pack_if.sv
// cmos_pixel_pack_if
//   Pixel-side output bundle of the camera capture stage.
//   master : driven by cmos_pixel_pack.
//   slave  : consumed by the SDRAM write-port FIFO / frame logic.
//   Signals:
//     pix_valid    one-cycle write strobe per packed RGB565 pixel
//     pix_data     RGB565 word {first byte, second byte}
//     frame_vsync  registered camera vsync, gated by frame qualification
//     frame_href   registered camera href, gated by frame qualification
//     frame_start  one-cycle pulse at each qualified frame start
//     frame_err    one-cycle pulse when a qualified frame had wrong geometry
interface cmos_pixel_pack_if;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        frame_vsync;
   logic        frame_href;
   logic        frame_start;
   logic        frame_err;

   modport master (
      output pix_valid, pix_data, frame_vsync, frame_href, frame_start, frame_err
   );

   modport slave (
      input pix_valid, pix_data, frame_vsync, frame_href, frame_start, frame_err
   );
endinterface

// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack
//   Capture stage between an OV5640 DVP bus and an SDRAM write FIFO.
//   Registers the camera bus, ignores the first WAIT_FRAMES frames after
//   en rises, packs byte pairs (high byte first) into RGB565 words and
//   checks each qualified frame against H_PIXEL x V_PIXEL.
//   Ports:
//     cam_pclk   camera pixel clock (only clock)
//     rst        asynchronous active-high reset
//     en         system init done; low drops frame qualification
//     cam_vsync  camera vsync (active high)
//     cam_href   camera href (active high)
//     cam_data   camera byte
//     pix        output bundle (pixel strobe/data, gated frame timing,
//                frame_start / frame_err pulses)
module cmos_pixel_pack #(
   parameter int WAIT_FRAMES = 10,
   parameter int H_PIXEL     = 1024,
   parameter int V_PIXEL     = 768
) (
   input  logic                     cam_pclk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     cam_vsync,
   input  logic                     cam_href,
   input  logic [7:0]               cam_data,
   cmos_pixel_pack_if.master        pix
);

   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_FRAMES - 1);
   localparam logic [10:0] H_CNT     = 11'(H_PIXEL);
   localparam logic [10:0] V_CNT     = 11'(V_PIXEL);
   localparam logic [10:0] CNT_MAX   = 11'h7FF;

   // input stage
   logic        vsync_d0, vsync_d1, href_d0, href_d1;
   logic [7:0]  data_d0;

   // qualification
   logic [3:0]  wait_cnt;
   logic        frame_ok;

   // packing
   logic        byte_phase;
   logic [7:0]  hi_byte;
   logic        pix_valid_reg;
   logic [15:0] pix_data_reg;

   // geometry check; *_sat remembers that a counter hit its ceiling
   logic [10:0] pix_cnt, line_cnt;
   logic        pix_sat, line_sat;
   logic        err_acc;
   logic        frame_start_reg, frame_err_reg;

   logic        vs_rise, href_fall, pack, active, line_bad;
   logic [10:0] line_cnt_inc, line_cnt_eff;
   logic        line_sat_inc, line_sat_eff, frame_bad;

   assign vs_rise   = vsync_d0 & ~vsync_d1;
   assign href_fall = href_d1 & ~href_d0;
   assign pack      = href_d0 & byte_phase;
   // en is looked at directly so that dropping it stops the strobe on the
   // very next edge instead of one cycle after frame_ok clears
   assign active    = frame_ok & en;

   // At the href falling edge pix_cnt already holds every pixel of the line
   // and byte_phase = 1 means an unpaired trailing byte.
   assign line_bad = pix_sat | (pix_cnt != H_CNT) | byte_phase;

   always_comb begin
      line_cnt_inc = line_cnt;
      line_sat_inc = line_sat;
      if (line_cnt == CNT_MAX) begin
         line_sat_inc = 1'b1;
      end else begin
         line_cnt_inc = line_cnt + 11'd1;
      end
   end

   // A line closing in the same cycle as the frame boundary belongs to the
   // frame that is ending, so the frame check sees it already counted.
   always_comb begin
      line_cnt_eff = href_fall ? line_cnt_inc : line_cnt;
      line_sat_eff = href_fall ? line_sat_inc : line_sat;
      frame_bad    = err_acc | (href_fall & line_bad) | line_sat_eff |
                     (line_cnt_eff != V_CNT);
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         vsync_d0 <= 1'b0;
         vsync_d1 <= 1'b0;
         href_d0  <= 1'b0;
         href_d1  <= 1'b0;
         data_d0  <= 8'h00;
      end else begin
         vsync_d0 <= cam_vsync;
         vsync_d1 <= vsync_d0;
         href_d0  <= cam_href;
         href_d1  <= href_d0;
         data_d0  <= cam_data;
      end
   end

   // frame_ok only rises on a vsync edge, so a frame is never entered midway
   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 4'd0;
         frame_ok <= 1'b0;
      end else if (!en) begin
         wait_cnt <= 4'd0;
         frame_ok <= 1'b0;
      end else if (vs_rise && !frame_ok) begin
         if (wait_cnt == WAIT_LAST) begin
            frame_ok <= 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         byte_phase    <= 1'b0;
         hi_byte       <= 8'h00;
         pix_valid_reg <= 1'b0;
         pix_data_reg  <= 16'h0000;
      end else begin
         pix_valid_reg <= 1'b0;
         if (!href_d0) begin
            byte_phase <= 1'b0;
         end else begin
            byte_phase <= ~byte_phase;
            if (!byte_phase) begin
               hi_byte <= data_d0;
            end else begin
               pix_data_reg  <= {hi_byte, data_d0};
               pix_valid_reg <= active;
            end
         end
      end
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         pix_cnt         <= 11'd0;
         pix_sat         <= 1'b0;
         line_cnt        <= 11'd0;
         line_sat        <= 1'b0;
         err_acc         <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_err_reg   <= 1'b0;
      end else begin
         frame_start_reg <= vs_rise & en & (frame_ok | (wait_cnt == WAIT_LAST));
         frame_err_reg   <= 1'b0;
         if (!active) begin
            pix_cnt  <= 11'd0;
            pix_sat  <= 1'b0;
            line_cnt <= 11'd0;
            line_sat <= 1'b0;
            err_acc  <= 1'b0;
         end else begin
            if (href_fall) begin
               pix_cnt  <= 11'd0;
               pix_sat  <= 1'b0;
               line_cnt <= line_cnt_inc;
               line_sat <= line_sat_inc;
               if (line_bad) err_acc <= 1'b1;
            end else if (pack) begin
               if (pix_cnt == CNT_MAX) pix_sat <= 1'b1;
               else                    pix_cnt <= pix_cnt + 11'd1;
            end
            if (vs_rise) begin
               frame_err_reg <= frame_bad;
               err_acc       <= 1'b0;
               line_cnt      <= 11'd0;
               line_sat      <= 1'b0;
            end
         end
      end
   end

   assign pix.pix_valid   = pix_valid_reg;
   assign pix.pix_data    = pix_data_reg;
   assign pix.frame_vsync = vsync_d0 & frame_ok;
   assign pix.frame_href  = href_d0 & frame_ok;
   assign pix.frame_start = frame_start_reg;
   assign pix.frame_err   = frame_err_reg;

endmodule
